// File: rtl/decoupled_v_rx_fifo_if.sv
// Bundle for the valid-only input stream and the ready/valid output stream of decoupled_v_rx_fifo.
interface decoupled_v_rx_fifo_if #(
    parameter int DataWidth = 64
);
    logic                 in_valid;
    logic [DataWidth-1:0] in_data;
    logic                 out_valid;
    logic [DataWidth-1:0] out_data;
    logic                 out_ready;

    // The FIFO sinks the input stream and sources the output stream.
    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output out_valid,
        output out_data
    );

    // The surrounding environment is the producer and the consumer.
    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  out_valid,
        input  out_data
    );
endinterface

// File: rtl/decoupled_v_rx_fifo.sv
// Buffers a valid-only stream into a small FIFO for a stallable consumer.
// Beats that arrive while full and not draining are dropped, counted and flagged.
module decoupled_v_rx_fifo #(
    parameter int DataWidth = 64,
    parameter int Depth     = 4,
    localparam int PtrW     = $clog2(Depth),
    localparam int CntW     = $clog2(Depth + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    decoupled_v_rx_fifo_if.slave   bus,
    output logic [CntW-1:0]        count,
    output logic                   almost_full,
    output logic                   overflow,
    output logic [15:0]            drop_count,
    input  logic                   clr_overflow
);

    logic [DataWidth-1:0] mem_q [Depth];
    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]      count_q, count_d;
    logic                 almost_full_q, almost_full_d;
    logic                 overflow_q, overflow_d;
    logic [15:0]          drop_count_q, drop_count_d;

    logic full;
    logic pop;
    logic push;
    logic drop;

    assign full = (count_q == CntW'(Depth));
    assign pop  = (count_q != '0) && bus.out_ready;
    assign push = bus.in_valid && (!full || pop);
    assign drop = bus.in_valid && full && !pop;

    always_comb begin
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        overflow_d    = overflow_q;
        drop_count_d  = drop_count_q;

        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A drop in the same cycle as a clear wins, so the new drop is never lost.
        if (drop) begin
            overflow_d = 1'b1;
            if (clr_overflow)
                drop_count_d = 16'd1;
            else if (drop_count_q != 16'hFFFF)
                drop_count_d = drop_count_q + 16'd1;
        end else if (clr_overflow) begin
            overflow_d   = 1'b0;
            drop_count_d = 16'd0;
        end

        almost_full_d = (count_d >= CntW'(Depth - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            almost_full_q <= 1'b0;
            overflow_q    <= 1'b0;
            drop_count_q  <= 16'd0;
        end else begin
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            almost_full_q <= almost_full_d;
            overflow_q    <= overflow_d;
            drop_count_q  <= drop_count_d;
        end
    end

    // Storage is not reset; a reset-cycle beat is blocked so it cannot land in the array.
    always_ff @(posedge clk) begin
        if (push && !rst)
            mem_q[wr_ptr_q] <= bus.in_data;
    end

    assign bus.out_valid = (count_q != '0);
    assign bus.out_data  = mem_q[rd_ptr_q];
    assign count         = count_q;
    assign almost_full   = almost_full_q;
    assign overflow      = overflow_q;
    assign drop_count    = drop_count_q;

endmodule
